punc_control_fsm: RTL

//  Multi-cycle LC3 control unit for PUnC; drives every control strobe of PUnCDatapath from ir and pc_br_en.

---
 rtl/punc_control_fsm_pkg.sv | 114 +++++++++++
 rtl/punc_ctrl_decode.sv | 41 ++++
 rtl/punc_control_fsm.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/punc_control_fsm_pkg.sv
// Shared encodings for the PUnC LC3 control unit: opcodes, FSM state codes,
// datapath select values, the decoded op-class bundle and the control bundle.
package punc_control_fsm_pkg;

  localparam int STATE_W = 3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC1  = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXEC2  = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd5;

  // LC3 opcodes, ir[15:12]
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation {s1,s0}
  localparam logic [1:0] ALU_OP_PASS = 2'b00;
  localparam logic [1:0] ALU_OP_ADD  = 2'b01;
  localparam logic [1:0] ALU_OP_AND  = 2'b10;
  localparam logic [1:0] ALU_OP_NOT  = 2'b11;

  // ALU A-input select
  localparam logic [1:0] ALU1_NONE = 2'b00;
  localparam logic [1:0] ALU1_RF   = 2'b01;
  localparam logic [1:0] ALU1_PC1  = 2'b10;
  localparam logic [1:0] ALU1_BASE = 2'b11;

  // ALU B-input select
  localparam logic [2:0] ALU2_NONE  = 3'b000;
  localparam logic [2:0] ALU2_RF    = 3'b001;
  localparam logic [2:0] ALU2_IMM5  = 3'b010;
  localparam logic [2:0] ALU2_OFF9  = 3'b011;
  localparam logic [2:0] ALU2_OFF11 = 3'b100;
  localparam logic [2:0] ALU2_OFF6  = 3'b101;

  // Register-file write data select
  localparam logic [1:0] RFW_ALU = 2'b00;
  localparam logic [1:0] RFW_MEM = 2'b01;
  localparam logic [1:0] RFW_PC1 = 2'b10;

  // Memory read-address select
  localparam logic [1:0] MADDR_ALU = 2'b00;
  localparam logic [1:0] MADDR_IND = 2'b01;
  localparam logic [1:0] MADDR_PC  = 2'b10;

  // PC load source select
  localparam logic [1:0] PCSRC_NONE = 2'b00;
  localparam logic [1:0] PCSRC_ALU  = 2'b01;
  localparam logic [1:0] PCSRC_RF   = 2'b10;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic is_br;
    logic is_add;
    logic is_ld;
    logic is_st;
    logic is_jsr;
    logic is_and;
    logic is_ldr;
    logic is_str;
    logic is_not;
    logic is_ldi;
    logic is_sti;
    logic is_jmp;
    logic is_lea;
    logic is_halt;
    logic is_nop;
  } op_class_t;

  // Full set of datapath control strobes
  typedef struct packed {
    logic       ir_ld;
    logic [1:0] alu_op;
    logic [1:0] alu1;
    logic [2:0] alu2;
    logic [1:0] rf_mux;
    logic [1:0] maddr;
    logic       mem_rw;
    logic       dr_sr;
    logic [1:0] pc_src;
    logic       pc_clr;
    logic       pc_ld;
    logic       pc_inc;
    logic       set_cc;
    logic       reg_rw;
    logic       st_state;
    logic       jsrr_state;
    logic       br_state;
    logic       state_ld;
  } ctrl_t;

  // Indirect loads/stores need a second execute cycle to use the latched pointer
  function automatic logic needs_exec2(input op_class_t cls);
    return cls.is_ldi | cls.is_sti;
  endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// Combinational instruction decoder: opcode -> one-hot op class, plus the
// immediate-form and PC-relative-JSR flags taken straight from the ir.
module punc_ctrl_decode
  import punc_control_fsm_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       ir_bit5,
  input  logic       ir_bit11,
  output op_class_t  op_class,
  output logic       imm_sel,
  output logic       jsr_pc_rel
);

  // Map opcode to exactly one class bit; reserved opcodes become NOPs
  always_comb begin
    op_class = '0;
    case (opcode)
      OP_BR:   op_class.is_br   = 1'b1;
      OP_ADD:  op_class.is_add  = 1'b1;
      OP_LD:   op_class.is_ld   = 1'b1;
      OP_ST:   op_class.is_st   = 1'b1;
      OP_JSR:  op_class.is_jsr  = 1'b1;
      OP_AND:  op_class.is_and  = 1'b1;
      OP_LDR:  op_class.is_ldr  = 1'b1;
      OP_STR:  op_class.is_str  = 1'b1;
      OP_NOT:  op_class.is_not  = 1'b1;
      OP_LDI:  op_class.is_ldi  = 1'b1;
      OP_STI:  op_class.is_sti  = 1'b1;
      OP_JMP:  op_class.is_jmp  = 1'b1;
      OP_LEA:  op_class.is_lea  = 1'b1;
      OP_HALT: op_class.is_halt = 1'b1;
      OP_RTI,
      OP_RES:  op_class.is_nop  = 1'b1;
      default: op_class.is_nop  = 1'b1;
    endcase
  end

  assign imm_sel    = ir_bit5;
  assign jsr_pc_rel = ir_bit11;

endmodule

// File: rtl/punc_control_fsm.sv
// Multi-cycle LC3 control unit for PUnC. Sequences INIT -> FETCH -> DECODE ->
// EXEC1 [-> EXEC2] -> FETCH and decodes every datapath strobe from state + ir.
// Only the state is registered; all strobes are decoded combinationally.
module punc_control_fsm
  import punc_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        pc_br_en,
  output logic        ir_ld,
  output logic        alu_s1_en,
  output logic        alu_s0_en,
  output logic [1:0]  alu_mux_1_en,
  output logic [2:0]  alu_mux_2_en,
  output logic [1:0]  mem_rf_mux_en,
  output logic [1:0]  mem_raddr_mux_en,
  output logic        mem_rw_en,
  output logic        reg_dr_sr_en,
  output logic [1:0]  pc_mux_en,
  output logic        pc_clr,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        set_cc_en,
  output logic        reg_rw_en,
  output logic        st_state,
  output logic        jsrr_state,
  output logic        br_state,
  output logic        state_ld
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_next_s;
  op_class_t          op_class_s;
  logic               imm_sel_s;
  logic               jsr_pc_rel_s;
  ctrl_t              ctrl_s;

  // Register fields (DR/SR numbers, offsets) are consumed by the datapath only
  logic ir_unused_s;
  assign ir_unused_s = ^{ir[10:6], ir[4:0]};

  punc_ctrl_decode u_decode (
    .opcode     (ir[15:12]),
    .ir_bit5    (ir[5]),
    .ir_bit11   (ir[11]),
    .op_class   (op_class_s),
    .imm_sel    (imm_sel_s),
    .jsr_pc_rel (jsr_pc_rel_s)
  );

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next_s = ST_INIT;
    case (state_r)
      ST_INIT:   state_next_s = ST_FETCH;
      ST_FETCH:  state_next_s = ST_DECODE;
      ST_DECODE: begin
        if (op_class_s.is_halt) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        if (needs_exec2(op_class_s)) begin
          state_next_s = ST_EXEC2;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_EXEC2:  state_next_s = ST_FETCH;
      ST_HALT:   state_next_s = ST_HALT;
      default:   state_next_s = ST_INIT;
    endcase
  end

  // Strobe decode: everything defaults to zero, each state raises only its own
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      ST_INIT: begin
        ctrl_s.pc_clr = 1'b1;
      end
      ST_FETCH: begin
        ctrl_s.maddr = MADDR_PC;
        ctrl_s.ir_ld = 1'b1;
      end
      ST_DECODE: begin
        ctrl_s.state_ld = 1'b1;
      end
      ST_EXEC1: begin
        ctrl_s.pc_inc = 1'b1;
        if (op_class_s.is_add || op_class_s.is_and) begin
          ctrl_s.dr_sr  = 1'b1;
          ctrl_s.alu1   = ALU1_RF;
          ctrl_s.alu2   = imm_sel_s ? ALU2_IMM5 : ALU2_RF;
          ctrl_s.alu_op = op_class_s.is_and ? ALU_OP_AND : ALU_OP_ADD;
          ctrl_s.rf_mux = RFW_ALU;
          ctrl_s.reg_rw = 1'b1;
          ctrl_s.set_cc = 1'b1;
        end else if (op_class_s.is_not) begin
          ctrl_s.dr_sr  = 1'b1;
          ctrl_s.alu1   = ALU1_RF;
          ctrl_s.alu_op = ALU_OP_NOT;
          ctrl_s.rf_mux = RFW_ALU;
          ctrl_s.reg_rw = 1'b1;
          ctrl_s.set_cc = 1'b1;
        end else if (op_class_s.is_ld) begin
          ctrl_s.alu1   = ALU1_PC1;
          ctrl_s.alu2   = ALU2_OFF9;
          ctrl_s.alu_op = ALU_OP_ADD;
          ctrl_s.maddr  = MADDR_ALU;
          ctrl_s.rf_mux = RFW_MEM;
          ctrl_s.reg_rw = 1'b1;
          ctrl_s.set_cc = 1'b1;
        end else if (op_class_s.is_ldr) begin
          ctrl_s.dr_sr  = 1'b1;
          ctrl_s.alu1   = ALU1_BASE;
          ctrl_s.alu2   = ALU2_OFF6;
          ctrl_s.alu_op = ALU_OP_ADD;
          ctrl_s.maddr  = MADDR_ALU;
          ctrl_s.rf_mux = RFW_MEM;
          ctrl_s.reg_rw = 1'b1;
          ctrl_s.set_cc = 1'b1;
        end else if (op_class_s.is_lea) begin
          ctrl_s.alu1   = ALU1_PC1;
          ctrl_s.alu2   = ALU2_OFF9;
          ctrl_s.alu_op = ALU_OP_ADD;
          ctrl_s.rf_mux = RFW_ALU;
          ctrl_s.reg_rw = 1'b1;
        end else if (op_class_s.is_st) begin
          ctrl_s.st_state = 1'b1;
          ctrl_s.alu1     = ALU1_PC1;
          ctrl_s.alu2     = ALU2_OFF9;
          ctrl_s.alu_op   = ALU_OP_ADD;
          ctrl_s.maddr    = MADDR_ALU;
          ctrl_s.mem_rw   = 1'b1;
        end else if (op_class_s.is_str) begin
          // base register comes from ir[8:6] on rf port r0
          ctrl_s.st_state = 1'b1;
          ctrl_s.dr_sr    = 1'b1;
          ctrl_s.alu1     = ALU1_BASE;
          ctrl_s.alu2     = ALU2_OFF6;
          ctrl_s.alu_op   = ALU_OP_ADD;
          ctrl_s.maddr    = MADDR_ALU;
          ctrl_s.mem_rw   = 1'b1;
        end else if (op_class_s.is_ldi || op_class_s.is_sti) begin
          // first cycle only latches the pointer; PC advances in EXEC2
          ctrl_s.pc_inc = 1'b0;
          ctrl_s.alu1   = ALU1_PC1;
          ctrl_s.alu2   = ALU2_OFF9;
          ctrl_s.alu_op = ALU_OP_ADD;
          ctrl_s.maddr  = MADDR_ALU;
        end else if (op_class_s.is_br) begin
          ctrl_s.br_state = 1'b1;
          ctrl_s.alu1     = ALU1_PC1;
          ctrl_s.alu2     = ALU2_OFF9;
          ctrl_s.alu_op   = ALU_OP_ADD;
          ctrl_s.pc_src   = PCSRC_ALU;
          ctrl_s.pc_ld    = pc_br_en;
        end else if (op_class_s.is_jmp) begin
          ctrl_s.dr_sr  = 1'b1;
          ctrl_s.pc_src = PCSRC_RF;
          ctrl_s.pc_ld  = 1'b1;
        end else if (op_class_s.is_jsr) begin
          // R7 <= pc+1 and the new PC are taken on the same edge, so a
          // JSRR through R7 jumps to the old R7 value
          ctrl_s.jsrr_state = 1'b1;
          ctrl_s.reg_rw     = 1'b1;
          ctrl_s.rf_mux     = RFW_PC1;
          ctrl_s.pc_ld      = 1'b1;
          if (jsr_pc_rel_s) begin
            ctrl_s.alu1   = ALU1_PC1;
            ctrl_s.alu2   = ALU2_OFF11;
            ctrl_s.alu_op = ALU_OP_ADD;
            ctrl_s.pc_src = PCSRC_ALU;
          end else begin
            ctrl_s.dr_sr  = 1'b1;
            ctrl_s.pc_src = PCSRC_RF;
          end
        end else begin
          // unsupported opcodes just step the PC
          ctrl_s.pc_inc = 1'b1;
        end
      end
      ST_EXEC2: begin
        ctrl_s.pc_inc = 1'b1;
        ctrl_s.maddr  = MADDR_IND;
        if (op_class_s.is_ldi) begin
          ctrl_s.rf_mux = RFW_MEM;
          ctrl_s.reg_rw = 1'b1;
          ctrl_s.set_cc = 1'b1;
        end else if (op_class_s.is_sti) begin
          ctrl_s.dr_sr  = 1'b0;
          ctrl_s.mem_rw = 1'b1;
        end else begin
          ctrl_s.pc_inc = 1'b1;
        end
      end
      ST_HALT: begin
        ctrl_s = '0;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

  assign ir_ld            = ctrl_s.ir_ld;
  assign alu_s1_en        = ctrl_s.alu_op[1];
  assign alu_s0_en        = ctrl_s.alu_op[0];
  assign alu_mux_1_en     = ctrl_s.alu1;
  assign alu_mux_2_en     = ctrl_s.alu2;
  assign mem_rf_mux_en    = ctrl_s.rf_mux;
  assign mem_raddr_mux_en = ctrl_s.maddr;
  assign mem_rw_en        = ctrl_s.mem_rw;
  assign reg_dr_sr_en     = ctrl_s.dr_sr;
  assign pc_mux_en        = ctrl_s.pc_src;
  assign pc_clr           = ctrl_s.pc_clr;
  assign pc_ld            = ctrl_s.pc_ld;
  assign pc_inc           = ctrl_s.pc_inc;
  assign set_cc_en        = ctrl_s.set_cc;
  assign reg_rw_en        = ctrl_s.reg_rw;
  assign st_state         = ctrl_s.st_state;
  assign jsrr_state       = ctrl_s.jsrr_state;
  assign br_state         = ctrl_s.br_state;
  assign state_ld         = ctrl_s.state_ld;

endmodule
